// File: rtl/disaggregator.sv
// Splits each wide word from an upstream FIFO into its narrow lanes and emits
// them one per cycle, with a run-time adjustable number of active lanes.
module disaggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [2:0]                        input_fetch_width
);

  localparam int HOLD_WIDTH = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [2:0] FW3 = 3'(FETCH_WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state_q, state_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [2:0]            idx_q, idx_d;
  logic [2:0]            width_q, width_d;
  logic [2:0]            pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;

  logic                  last_emit;
  logic                  strobe_ok;
  logic [2:0]            next_width;

  // Handshakes are gated by rst_n so nothing moves while reset is held.
  always_comb begin
    receiver_enq = rst_n && (state_q == EMIT) && receiver_full_n;
    last_emit    = receiver_enq && (idx_q == width_q - 3'd1);
    sender_deq   = rst_n && ((state_q == IDLE) || last_emit) && sender_empty_n;
  end

  always_comb begin
    receiver_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (idx_q == i[2:0]) receiver_data = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    width_d    = width_q;

    strobe_ok  = change_fetch_width && (input_fetch_width != 3'd0) &&
                 (input_fetch_width <= FW3);
    pend_d     = strobe_ok ? input_fetch_width : pend_q;
    pend_vld_d = pend_vld_q || strobe_ok;
    next_width = pend_vld_d ? pend_d : width_q;

    // Width only switches on a word boundary, so a word never changes size mid-way.
    if ((state_q == IDLE) || sender_deq) begin
      width_d    = next_width;
      pend_vld_d = 1'b0;
    end

    if (sender_deq) begin
      hold_d  = sender_data;
      idx_d   = 3'd0;
      state_d = EMIT;
    end else if (last_emit) begin
      idx_d   = 3'd0;
      state_d = IDLE;
    end else if (receiver_enq) begin
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      // NOTE: the hold register is reset too, so receiver_data reads zero in reset.
      hold_q     <= '0;
      idx_q      <= 3'd0;
      width_q    <= FW3;
      pend_q     <= 3'd0;
      pend_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      width_q    <= width_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Self-checking bench for disaggregator: a queue-level model of the upstream
// FIFO and the expected narrow-word stream is checked every cycle.
module tb_disaggregator;

  localparam int DW = 8;
  localparam int FW = 6;
  localparam int HW = FW * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] sender_data;
  logic          sender_empty_n;
  logic          sender_deq;
  logic [DW-1:0] receiver_data;
  logic          receiver_full_n;
  logic          receiver_enq;
  logic          change_fetch_width;
  logic [2:0]    input_fetch_width;

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  always #5 clk = ~clk;

  logic [HW-1:0] word_q[$];   // upstream FIFO contents
  logic [DW-1:0] exp_q[$];    // narrow words still owed by the DUT
  int            model_w;
  int            checks;
  int            errors;
  int            enq_count;
  int            lanes_owed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] make_word(input int base);
    logic [HW-1:0] w;
    w = '0;
    for (int i = 0; i < FW; i++) w[i*DW +: DW] = 8'(base + i);
    return w;
  endfunction

  task automatic drive_src();
    sender_empty_n = (word_q.size() > 0);
    sender_data    = (word_q.size() > 0) ? word_q[0] : '0;
  endtask

  task automatic push_word(input logic [HW-1:0] w);
    word_q.push_back(w);
    drive_src();
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // update the source FIFO just after the rising edge.
  task automatic step();
    bit            pop;
    bit            exp_deq;
    bit            exp_enq;
    logic [HW-1:0] w;
    pop = 1'b0;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_enq",  64'(receiver_enq),  64'd0);
      check("rst_deq",  64'(sender_deq),    64'd0);
      check("rst_data", 64'(receiver_data), 64'd0);
      exp_q.delete();
      model_w = FW;
    end else begin
      exp_deq = (word_q.size() > 0) &&
                ((exp_q.size() == 0) || ((exp_q.size() == 1) && receiver_full_n));
      exp_enq = (exp_q.size() > 0) && receiver_full_n;
      check("deq", 64'(sender_deq),   64'(exp_deq));
      check("enq", 64'(receiver_enq), 64'(exp_enq));
      if (receiver_enq && exp_q.size() > 0) begin
        check("data", 64'(receiver_data), 64'(exp_q.pop_front()));
        enq_count++;
      end
      if (change_fetch_width && int'(input_fetch_width) >= 1 && int'(input_fetch_width) <= FW)
        model_w = int'(input_fetch_width);
      if (sender_deq && word_q.size() > 0) begin
        w = word_q[0];
        for (int i = 0; i < model_w; i++) exp_q.push_back(w[i*DW +: DW]);
        lanes_owed += model_w;
        pop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (pop) void'(word_q.pop_front());
    change_fetch_width = 1'b0;
    drive_src();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    receiver_full_n = 1'b1;
    while ((exp_q.size() > 0 || word_q.size() > 0) && n < 500) begin
      step();
      n++;
    end
    step();
    check(tag, 64'(exp_q.size() + word_q.size()), 64'd0);
  endtask

  initial begin
    bit done;
    int words_sent;
    int n;
    checks = 0; errors = 0; enq_count = 0; lanes_owed = 0; model_w = FW;
    rst_n = 1'b0;
    receiver_full_n = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width = 3'd0;
    drive_src();

    step();
    step();
    #1 rst_n = 1'b1;
    step();

    // Single word at full width.
    enq_count = 0;
    push_word(make_word(8'h10));
    drain("s1_drain");
    check("s1_count", 64'(enq_count), 64'd6);

    // Two queued words stream back to back.
    enq_count = 0;
    push_word(make_word(8'h00));
    push_word(make_word(8'h06));
    drain("s2_drain");
    check("s2_count", 64'(enq_count), 64'd12);

    // Width change to 4 while lane 2 of the current word is emitted.
    enq_count = 0;
    done = 1'b0;
    push_word(make_word(8'h20));
    push_word(make_word(8'h30));
    push_word(make_word(8'h40));
    for (int c = 0; c < 40; c++) begin
      if (!done && exp_q.size() == 4) begin
        change_fetch_width = 1'b1;
        input_fetch_width  = 3'd4;
        done = 1'b1;
      end
      step();
    end
    drain("s3_drain");
    check("s3_count", 64'(enq_count), 64'd14);

    // Out-of-range widths are ignored; width stays 4.
    enq_count = 0;
    change_fetch_width = 1'b1;
    input_fetch_width  = 3'd0;
    step();
    push_word(make_word(8'h50));
    change_fetch_width = 1'b1;
    input_fetch_width  = 3'd7;
    step();
    drain("s4_drain");
    check("s4_count", 64'(enq_count), 64'd4);

    // Reset pulse at lane 3 discards the word and restores full width.
    push_word(make_word(8'h60));
    push_word(make_word(8'h70));
    n = 0;
    step();
    while (exp_q.size() != 1 && n < 20) begin
      step();
      n++;
    end
    check("s5_reach_lane3", 64'(exp_q.size()), 64'd1);
    rst_n = 1'b0;
    #1;
    check("s5_enq_now", 64'(receiver_enq), 64'd0);
    check("s5_deq_now", 64'(sender_deq),   64'd0);
    step();
    rst_n = 1'b1;
    enq_count = 0;
    drain("s5_drain");
    check("s5_count", 64'(enq_count), 64'd6);

    // Random back-pressure, random strobes, 100 words.
    enq_count = 0;
    lanes_owed = 0;
    words_sent = 0;
    n = 0;
    while (words_sent < 100 && n < 20000) begin
      if (word_q.size() < 3 && $urandom_range(0, 3) != 0) begin
        push_word({$urandom, $urandom});
        words_sent++;
      end
      receiver_full_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        change_fetch_width = 1'b1;
        input_fetch_width  = 3'($urandom_range(0, 7));
      end
      step();
      n++;
    end
    drain("rand_drain");
    check("rand_sent",  64'(words_sent), 64'd100);
    check("rand_count", 64'(enq_count),  64'(lanes_owed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
